// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: core port, loader port, shared read data and data-memory command.
// The slave modport is the arbiter's view; master is the requesters' and memory's side.
interface dmem_arb_if #(
  parameter int unsigned W  = 8,
  parameter int unsigned AW = 8
);
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [W-1:0]  c_wdata;
  logic          c_gnt;
  logic          c_rvalid;

  logic          l_req;
  logic          l_we;
  logic          l_lock;
  logic [AW-1:0] l_addr;
  logic [W-1:0]  l_wdata;
  logic          l_gnt;
  logic          l_rvalid;

  logic [W-1:0]  rdata;

  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    input  mem_rdata,
    output c_gnt, c_rvalid, l_gnt, l_rvalid, rdata,
    output mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    output mem_rdata,
    input  c_gnt, c_rvalid, l_gnt, l_rvalid, rdata,
    input  mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter (core vs. loader) with starvation guard and loader burst lock.
// Define DMEM_ARB_RR_EN for round-robin base policy; default is fixed priority, core first.
module dmem_arb #(
  parameter int unsigned W          = 8,
  parameter int unsigned AW         = 8,
  parameter int unsigned STARVE_LIM = 8,
  parameter int unsigned LOCK_MAX   = 16
) (
  input logic       CLK,
  input logic       reset_n,
  dmem_arb_if.slave bus
);
  localparam int unsigned SW = $clog2(STARVE_LIM + 1);
  localparam int unsigned LW = $clog2(LOCK_MAX + 1);

  localparam logic [0:0] UNLOCKED = 1'b0;
  localparam logic [0:0] LOCKED   = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic [W-1:0]  rdata_q;
  logic          c_rvalid_q, l_rvalid_q;

  logic lock_hold, starve_hit, base_l, pick_l;
  logic c_gnt, l_gnt;

  // The lock only survives while the loader keeps both req and lock up and has budget left.
  assign lock_hold  = (state_q == LOCKED) && bus.l_req && bus.l_lock &&
                      (lock_cnt_q < LW'(LOCK_MAX));
  assign starve_hit = bus.l_req && (starve_q == SW'(STARVE_LIM));

`ifdef DMEM_ARB_RR_EN
  logic last_l_q;

  // On contention the port that did not win last time goes first.
  assign base_l = bus.l_req && (!bus.c_req || !last_l_q);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      last_l_q <= 1'b1;
    end else if (c_gnt) begin
      last_l_q <= 1'b0;
    end else if (l_gnt) begin
      last_l_q <= 1'b1;
    end
  end
`else
  assign base_l = bus.l_req && !bus.c_req;
`endif

  assign pick_l = lock_hold || starve_hit || base_l;

  // Grants are gated by reset so the command bus is quiet while reset is held.
  assign c_gnt = reset_n && bus.c_req && !pick_l;
  assign l_gnt = reset_n && bus.l_req && pick_l;

  always_comb begin
    starve_d   = '0;
    state_d    = UNLOCKED;
    lock_cnt_d = '0;
    if (bus.l_req && !l_gnt) begin
      starve_d = (starve_q == SW'(STARVE_LIM)) ? starve_q : starve_q + SW'(1);
    end
    if (l_gnt && bus.l_lock) begin
      state_d    = LOCKED;
      lock_cnt_d = lock_hold ? lock_cnt_q + LW'(1) : LW'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= UNLOCKED;
      starve_q   <= '0;
      lock_cnt_q <= '0;
      rdata_q    <= '0;
      c_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lock_cnt_q <= lock_cnt_d;
      c_rvalid_q <= c_gnt && !bus.c_we;
      l_rvalid_q <= l_gnt && !bus.l_we;
      if ((c_gnt && !bus.c_we) || (l_gnt && !bus.l_we)) begin
        rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.c_gnt     = c_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.c_rvalid  = c_rvalid_q;
  assign bus.l_rvalid  = l_rvalid_q;
  assign bus.rdata     = rdata_q;

  assign bus.mem_re    = (c_gnt && !bus.c_we) || (l_gnt && !bus.l_we);
  assign bus.mem_we    = (c_gnt && bus.c_we) || (l_gnt && bus.l_we);
  assign bus.mem_addr  = l_gnt ? bus.l_addr  : (c_gnt ? bus.c_addr  : '0);
  assign bus.mem_wdata = l_gnt ? bus.l_wdata : (c_gnt ? bus.c_wdata : '0);
endmodule
